// File: rtl/regfile_banked.sv
// Banked register file: DEPTH x DATA_W active bank with write-to-read bypass, condition bit,
// and a shadow bank filled or drained one register per cycle by a save/restore sequencer.
module regfile_banked #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic              write_CB_i,
  input  logic              cb_data_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic              save_i,
  input  logic              restore_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              cb_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] active_q [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic              cb_q;
  logic              shadow_cb_q;

  logic idle;
  logic wr_ok;
  logic cb_wr;
  logic last_idx;

  assign idle     = (state_q == IDLE);
  assign wr_ok    = write_i && idle && !((ZERO_REG != 0) && (write_addr_i == '0));
  assign cb_wr    = write_CB_i && idle;
  assign last_idx = (idx_q == ADDR_W'(DEPTH - 1));

  // Register 0 masking wins over bypass; outputs are forced low while reset is held.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = active_q[addr];
    if (wr_ok && (addr == write_addr_i)) val = write_data_i;
    if ((ZERO_REG != 0) && (addr == '0)) val = '0;
    if (!reset_n_i) val = '0;
    return val;
  endfunction

  always_comb begin
    rs_data_o = read_port(rs_addr_i);
    rt_data_o = read_port(rt_addr_i);
    cb_data_o = reset_n_i && (cb_wr ? cb_data_i : cb_q);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
      cb_q        <= 1'b0;
      shadow_cb_q <= 1'b0;
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_ok) active_q[write_addr_i] <= write_data_i;
          if (cb_wr) cb_q <= cb_data_i;
          if (save_i) begin
            state_q <= SAVE;
            idx_q   <= '0;
            busy_o  <= 1'b1;
          end else if (restore_i) begin
            state_q <= RESTORE;
            idx_q   <= '0;
            busy_o  <= 1'b1;
          end
        end
        SAVE: begin
          shadow_q[idx_q] <= active_q[idx_q];
          if (last_idx) begin
            shadow_cb_q <= cb_q;
            state_q     <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        RESTORE: begin
          active_q[idx_q] <= shadow_q[idx_q];
          if (last_idx) begin
            cb_q    <= shadow_cb_q;
            state_q <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_banked.sv
// Bench for regfile_banked: one instance with ZERO_REG=0 and one with ZERO_REG=1 share stimulus;
// a transaction-level model predicts every output each cycle, directed checks pin key values.
module tb_regfile_banked;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wcb;
  logic       cb_in;
  logic [2:0] rs_addr;
  logic [2:0] rt_addr;
  logic       save;
  logic       restore;

  logic [7:0] rs0, rt0, rs1, rt1;
  logic       cb0, cb1, busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  regfile_banked #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .write_i(wr_en), .write_addr_i(wr_addr),
    .write_data_i(wr_data), .write_CB_i(wcb), .cb_data_i(cb_in), .rs_addr_i(rs_addr),
    .rt_addr_i(rt_addr), .save_i(save), .restore_i(restore), .rs_data_o(rs0),
    .rt_data_o(rt0), .cb_data_o(cb0), .busy_o(busy0), .done_o(done0)
  );

  regfile_banked #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
    .clk_i(clk), .reset_n_i(reset_n), .write_i(wr_en), .write_addr_i(wr_addr),
    .write_data_i(wr_data), .write_CB_i(wcb), .cb_data_i(cb_in), .rs_addr_i(rs_addr),
    .rt_addr_i(rt_addr), .save_i(save), .restore_i(restore), .rs_data_o(rs1),
    .rt_data_o(rt1), .cb_data_o(cb1), .busy_o(busy1), .done_o(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: index 0 is the plain instance, index 1 the zero-register instance.
  logic [7:0] m_act [2][8];
  logic [7:0] m_sh  [2][8];
  logic       m_cb  [2];
  logic       m_shcb[2];
  int         m_left;   // copy cycles still to run; 0 means accepting writes/requests
  bit         m_rest;   // current copy direction is shadow -> active
  bit         m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 8; a++) begin
          m_act[i][a] <= 8'h00;
          m_sh[i][a]  <= 8'h00;
        end
        m_cb[i]   <= 1'b0;
        m_shcb[i] <= 1'b0;
      end
      m_left <= 0;
      m_rest <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        for (int i = 0; i < 2; i++) begin
          if (wr_en && !(i == 1 && wr_addr == 3'd0)) m_act[i][wr_addr] <= wr_data;
          if (wcb) m_cb[i] <= cb_in;
        end
        if (save || restore) begin
          m_left <= 8;
          m_rest <= !save;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_rest) m_act[i][8 - m_left] <= m_sh[i][8 - m_left];
          else        m_sh[i][8 - m_left]  <= m_act[i][8 - m_left];
          if (m_left == 1) begin
            if (m_rest) m_cb[i]   <= m_shcb[i];
            else        m_shcb[i] <= m_cb[i];
          end
        end
        if (m_left == 1) m_done <= 1'b1;
        m_left <= m_left - 1;
      end
    end
  end

  function automatic logic [7:0] exp_rd(input int i, input logic [2:0] a);
    if (!reset_n) return 8'h00;
    if (i == 1 && a == 3'd0) return 8'h00;
    if (m_left == 0 && wr_en && !(i == 1 && wr_addr == 3'd0) && a == wr_addr) return wr_data;
    return m_act[i][a];
  endfunction

  function automatic logic exp_cb(input int i);
    if (!reset_n) return 1'b0;
    if (m_left == 0 && wcb) return cb_in;
    return m_cb[i];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rs0", rs0, exp_rd(0, rs_addr));
      chk("model_rt0", rt0, exp_rd(0, rt_addr));
      chk("model_rs1", rs1, exp_rd(1, rs_addr));
      chk("model_rt1", rt1, exp_rd(1, rt_addr));
      chk("model_cb0", cb0, exp_cb(0));
      chk("model_cb1", cb1, exp_cb(1));
      chk("model_busy0", busy0, reset_n && (m_left != 0));
      chk("model_busy1", busy1, reset_n && (m_left != 0));
      chk("model_done0", done0, reset_n && m_done);
      chk("model_done1", done1, reset_n && m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int busy_n;
  int done_n;

  initial begin
    wr_en = 0; wr_addr = 0; wr_data = 0; wcb = 0; cb_in = 0;
    rs_addr = 0; rt_addr = 0; save = 0; restore = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_en = 1;
    chk("reset_rs", rs0, 8'h00);
    chk("reset_cb", cb0, 1'b0);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_done", done0, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Bypass on write and readback from storage
    wr_en = 1; wr_addr = 3'd0; wr_data = 8'h11; rt_addr = 3'd0;
    #1 chk("bypass_rt", rt0, 8'h11);
    chk("zero_bypass_rt", rt1, 8'h00);
    tick();
    wr_en = 0;
    #1 chk("stored_rt", rt0, 8'h11);

    wr_en = 1; wr_addr = 3'd1; wr_data = 8'h22;
    tick();
    wr_addr = 3'd2; wr_data = 8'h33; rs_addr = 3'd1; rt_addr = 3'd2; wcb = 1; cb_in = 1;
    #1 chk("storage_rs", rs0, 8'h22);
    chk("bypass_rt2", rt0, 8'h33);
    chk("cb_bypass", cb0, 1'b1);
    tick();
    wr_en = 0; wcb = 0;
    #1 chk("cb_held", cb0, 1'b1);
    chk("stored_rt2", rt0, 8'h33);

    // Fill, then save with writes and requests attempted while busy
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_addr = 3'(k); wr_data = 8'hA0 + 8'(k);
      tick();
    end
    wr_en = 0; wcb = 1; cb_in = 1;
    tick();
    wcb = 0; save = 1;
    tick();
    save = 0; busy_n = 0; done_n = 0;
    for (int n = 0; n < 12; n++) begin
      if (n == 2) begin
        wr_en = 1; wr_addr = 3'd3; wr_data = 8'hFF; rs_addr = 3'd3; save = 1; restore = 1;
        #1 chk("busy_no_bypass", rs0, 8'hA3);
      end
      if (n == 3) begin
        wr_en = 0; save = 0; restore = 0;
      end
      busy_n += int'(busy0);
      done_n += int'(done0);
      tick();
    end
    chk("save_busy_cycles", busy_n, 8);
    chk("save_done_pulses", done_n, 1);
    chk("busy_write_dropped", rs0, 8'hA3);

    // Clear active bank and cb, then restore
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_addr = 3'(k); wr_data = 8'h00;
      tick();
    end
    wr_en = 0; wcb = 1; cb_in = 0;
    tick();
    wcb = 0;
    #1 chk("cb_cleared", cb0, 1'b0);
    restore = 1;
    tick();
    restore = 0;
    repeat (10) tick();
    for (int k = 0; k < 8; k++) begin
      rs_addr = 3'(k);
      #1 chk("restored_reg", rs0, 8'hA0 + 8'(k));
    end
    chk("restored_cb", cb0, 1'b1);

    // Simultaneous save and restore: save must win, so active keeps the new value
    wr_en = 1; wr_addr = 3'd5; wr_data = 8'h77;
    tick();
    wr_en = 0; save = 1; restore = 1;
    tick();
    save = 0; restore = 0;
    repeat (10) tick();
    rs_addr = 3'd5;
    #1 chk("save_wins", rs0, 8'h77);

    // Hard-wired zero register
    wr_en = 1; wr_addr = 3'd0; wr_data = 8'h55; rs_addr = 3'd0;
    #1 chk("zero_write_cycle", rs1, 8'h00);
    chk("nonzero_write_cycle", rs0, 8'h55);
    tick();
    wr_en = 0;
    #1 chk("zero_after", rs1, 8'h00);
    chk("nonzero_after", rs0, 8'h55);

    // Reset in the middle of a restore
    restore = 1;
    tick();
    restore = 0;
    repeat (4) tick();
    chk("mid_restore_busy", busy0, 1'b1);
    reset_n = 1'b0;
    #1 chk("abort_busy", busy0, 1'b0);
    chk("abort_done", done0, 1'b0);
    chk("abort_cb", cb0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      rs_addr = 3'(k); rt_addr = 3'(k);
      #1 chk("abort_rs", rs0, 8'h00);
      chk("abort_rt", rt0, 8'h00);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    done_n = 0;
    for (int n = 0; n < 12; n++) begin
      done_n += int'(done0);
      tick();
    end
    chk("no_done_after_abort", done_n, 0);
    for (int k = 0; k < 8; k++) begin
      rs_addr = 3'(k);
      #1 chk("cleared_reg", rs0, 8'h00);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
